fpf_encoder_iter: RTL
=====================

Name: fpf_encoder_iter

Overview:
- Parametrised, multi-cycle Fibonacci-weighted forbidden-pattern-free (FPF) crosstalk-avoidance encoder with valid/ready handshakes on both sides.
- Generalises the fixed-width single-cycle FPF encoder in three ways: any codeword width, a configurable number of code bits resolved per cycle (area/latency trade-off), and an out-of-range input check.
- Sits between the data source and the bus driver of an FPF-coded on-chip link.

Parameters:
- CODE_W, 25: codeword width in bits. Legal range 3..40.
- BITS_PER_CYCLE, 1: code bits resolved per RUN cycle. Legal range 1..CODE_W-1.
- DATA_W, derived localparam (not overridable): ceil(log2(F(CODE_W+2))), with F(1)=F(2)=1. For CODE_W=25, F(27)=196418 and DATA_W=18.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  binary value to encode.
- out_valid  out  1  out_code/out_err valid.
- out_ready  in  1  sink accepts the output.
- out_code  out  CODE_W  FPF codeword.
- out_err  out  1  the input was out of range.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Weights: code bit k has weight w_k = F(k+1), so w0=1, w1=1, w2=2, w3=3, ...
  - Weights w_0..w_CODE_W are compile-time constants produced by a constant function.
- Legal input range: 0..F(CODE_W+2)-1.
- Reset (reset_n=0, async) forces:
  - state = IDLE, in_ready = 1 once reset releases, out_valid = 0, out_code = 0, out_err = 0.
  - Internal remainder, bit index and previous-bit register are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture in_data and set: r = in_data, k = CODE_W-1, prev = 0, code register = 0.
  - If in_data >= F(CODE_W+2): out_err = 1, out_code stays 0, next state = DONE (RUN is skipped).
  - Otherwise next state = RUN.
- RUN (in_ready = 0): for each of up to BITS_PER_CYCLE indices k, descending, while k >= 1:
  - If r < w_k: bit = 0.
  - Else if r >= w_(k+1): bit = 1.
  - Else: bit = prev.
  - If bit = 1, r = r - w_k.
  - Then prev = bit and k = k - 1.
  - Bits within one cycle are resolved as a combinational chain.
  - When k reaches 0 in the cycle: bit0 = r[0] (r is 0 or 1 at this point), and next state = DONE.
- DONE:
  - out_valid = 1; out_code and out_err are held stable while out_ready = 0.
  - On out_ready: go to IDLE, drop out_valid, clear out_err. out_code keeps its value.
  - in_ready is 0 in DONE, so there is no same-cycle accept.
- Latency from the accept edge to out_valid high:
  - Legal input: ceil((CODE_W-1)/BITS_PER_CYCLE) + 1 cycles (25 for the defaults; 7 for BITS_PER_CYCLE=4).
  - Out-of-range input: 1 cycle.
- Throughput: one word per latency + 1 cycles minimum.
- Width rules:
  - r is DATA_W bits wide, and subtraction never underflows because it only happens when r >= w_k.
  - Comparisons use DATA_W+1 bits so that w_CODE_W = F(CODE_W+1) fits.
- Output property: every legal codeword contains neither 010 nor 101 in any three adjacent bits.
- in_data changes while in_ready = 0 are ignored.
- Reset asserted mid-RUN or mid-DONE aborts immediately; there is no partial output.

Test Plan:
- CODE_W=25, BPC=1, input 0 -> out_code=0x0000000, out_err=0, out_valid rises exactly 25 cycles after the accept edge.
- Inputs 1, 2, 3, 4 in sequence -> out_code = 0x1, 0x3, 0x6, 0x7, each with out_err=0.
- Input 196417 -> out_code=0x1FFFFFF. Input 196418 -> out_err=1, out_code=0, out_valid one cycle after accept.
- Exhaustive sweep:
  - CODE_W=12, BPC in {1, 3, 11}, all inputs 0..376.
  - Decoded weighted sum equals the input.
  - No 010/101 pattern appears in any codeword.
  - Latency matches the formula.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_code/out_err stable, in_ready=0.
  - Release -> IDLE next cycle, in_ready=1.
- Assert reset_n low mid-RUN (cycle 7 of 25) -> outputs go to reset values asynchronously.
  - After release, input 3 encodes to 0x6 with full latency.

Source files
------------

// File: rtl/fpf_encoder_iter.sv
// Multi-cycle Fibonacci-weighted forbidden-pattern-free (FPF) encoder.
// Resolves BITS_PER_CYCLE code bits per cycle, MSB first, with valid/ready on both sides.

function automatic longint unsigned fpf_encoder_iter_fib(input int unsigned n);
  longint unsigned a;
  longint unsigned b;
  longint unsigned t;
  a = 64'd0;
  b = 64'd1;
  for (int unsigned i = 0; i < n; i++) begin
    t = a + b;
    a = b;
    b = t;
  end
  return a;
endfunction

module fpf_encoder_iter #(
  parameter  int unsigned CODE_W         = 25,
  parameter  int unsigned BITS_PER_CYCLE = 1,
  localparam int unsigned DATA_W         = $clog2(fpf_encoder_iter_fib(CODE_W + 2))
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err
);

  localparam int unsigned CMP_W = DATA_W + 1;
  localparam int unsigned IDX_W = $clog2(CODE_W + 1);

  typedef logic [CODE_W:0][CMP_W-1:0] w_tab_t;

  // w_k = F(k+1); one extra bit so w_CODE_W fits alongside the comparisons
  function automatic w_tab_t weights();
    w_tab_t t;
    for (int unsigned k = 0; k <= CODE_W; k++) begin
      t[k] = CMP_W'(fpf_encoder_iter_fib(k + 1));
    end
    return t;
  endfunction

  localparam w_tab_t           W     = weights();
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(fpf_encoder_iter_fib(CODE_W + 2));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_out_err;
  logic [CODE_W-1:0]   r_code;
  logic [DATA_W-1:0]   r_rem;
  logic [IDX_W-1:0]    r_idx;
  logic                r_prev;

  logic [DATA_W-1:0]   w_rem;
  logic [IDX_W-1:0]    w_idx;
  logic                w_prev;
  logic                w_bit;
  logic                w_last;
  logic [CODE_W-1:0]   w_code;
  logic                w_oor;

  assign w_oor = ({1'b0, in_data} >= LIMIT);

  // One cycle's worth of bit decisions as a combinational chain
  always_comb begin
    w_rem  = r_rem;
    w_idx  = r_idx;
    w_prev = r_prev;
    w_code = r_code;
    w_bit  = 1'b0;
    w_last = 1'b0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (w_idx != '0) begin
        if ({1'b0, w_rem} < W[w_idx]) begin
          w_bit = 1'b0;
        end else if ({1'b0, w_rem} >= W[w_idx + IDX_W'(1)]) begin
          w_bit = 1'b1;
        end else begin
          w_bit = w_prev;
        end
        if (w_bit) begin
          w_rem = w_rem - DATA_W'(W[w_idx]);
        end
        w_code[w_idx] = w_bit;
        w_prev        = w_bit;
        w_idx         = w_idx - IDX_W'(1);
      end
    end
    if (w_idx == '0) begin
      w_code[0] = w_rem[0];
      w_last    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_code      <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_prev      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_rem      <= in_data;
            r_idx      <= IDX_W'(CODE_W - 1);
            r_prev     <= 1'b0;
            r_code     <= '0;
            if (w_oor) begin
              r_out_err <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          r_rem  <= w_rem;
          r_idx  <= w_idx;
          r_prev <= w_prev;
          r_code <= w_code;
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Valid rises one cycle after entering DONE; code is kept after the handshake
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_code  = r_code;
  assign out_err   = r_out_err;

endmodule
